// File: rtl/ram_port_arbiter.sv
// Single-owner req/ack arbiter in front of a single-port RAM (registered address/data/wren).
// Define ARB_WR_PRIORITY_EN for fixed write priority; otherwise ties alternate round-robin.
module ram_port_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_ack,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_wren,
   input  logic [DATA_W-1:0] ram_q,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, WRITE, READ, ACK} state_t;
   typedef enum logic {GRANT_READ, GRANT_WRITE} grant_t;

   // READ lasts RD_LAT+1 cycles: the counter runs 0..RD_LAT and ram_q is captured on the last edge.
   localparam logic [1:0] LAST_WAIT = 2'(RD_LAT);

   state_t              state_q, state_d;
   grant_t              lastGrant_q, lastGrant_d;
   logic [1:0]          waitCnt_q, waitCnt_d;
   logic [ADDR_W-1:0]   ramAddress_q, ramAddress_d;
   logic [DATA_W-1:0]   ramData_q, ramData_d;
   logic                ramWren_q, ramWren_d;
   logic                wrAck_q, wrAck_d;
   logic                rdAck_q, rdAck_d;
   logic [DATA_W-1:0]   rdData_q, rdData_d;
   logic                grantWrite;
   logic                grantRead;

   always_comb begin
`ifdef ARB_WR_PRIORITY_EN
      grantWrite = wr_req;
`else
      grantWrite = wr_req && (!rd_req || (lastGrant_q == GRANT_READ));
`endif
      grantRead = rd_req && !grantWrite;
   end

   always_comb begin
      state_d      = state_q;
      lastGrant_d  = lastGrant_q;
      waitCnt_d    = waitCnt_q;
      ramAddress_d = ramAddress_q;
      ramData_d    = ramData_q;
      ramWren_d    = 1'b0;
      wrAck_d      = 1'b0;
      rdAck_d      = 1'b0;
      rdData_d     = rdData_q;
      case (state_q)
         IDLE: begin
            if (grantWrite) begin
               ramAddress_d = wr_addr;
               ramData_d    = wr_data;
               ramWren_d    = 1'b1;
               lastGrant_d  = GRANT_WRITE;
               state_d      = WRITE;
            end else if (grantRead) begin
               ramAddress_d = rd_addr;
               waitCnt_d    = 2'd0;
               lastGrant_d  = GRANT_READ;
               state_d      = READ;
            end
         end
         WRITE: begin
            wrAck_d = 1'b1;
            state_d = ACK;
         end
         READ: begin
            if (waitCnt_q == LAST_WAIT) begin
               rdData_d = ram_q;
               rdAck_d  = 1'b1;
               state_d  = ACK;
            end else begin
               waitCnt_d = waitCnt_q + 2'd1;
            end
         end
         // No arbitration here, so the requester has one edge to drop req after seeing its ack.
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         lastGrant_q  <= GRANT_READ;
         waitCnt_q    <= 2'd0;
         ramAddress_q <= '0;
         ramData_q    <= '0;
         ramWren_q    <= 1'b0;
         wrAck_q      <= 1'b0;
         rdAck_q      <= 1'b0;
         rdData_q     <= '0;
      end else begin
         state_q      <= state_d;
         lastGrant_q  <= lastGrant_d;
         waitCnt_q    <= waitCnt_d;
         ramAddress_q <= ramAddress_d;
         ramData_q    <= ramData_d;
         ramWren_q    <= ramWren_d;
         wrAck_q      <= wrAck_d;
         rdAck_q      <= rdAck_d;
         rdData_q     <= rdData_d;
      end
   end

   assign wr_ack      = wrAck_q;
   assign rd_ack      = rdAck_q;
   assign rd_data     = rdData_q;
   assign ram_address = ramAddress_q;
   assign ram_data    = ramData_q;
   assign ram_wren    = ramWren_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: RD_LAT=1 instance for traffic, RD_LAT=3 instance for reset abort.
module tb_ram_port_arbiter;

   typedef struct {
      bit          isWrite;
      logic [31:0] data;
   } ackExp_t;

   typedef struct {
      logic [15:0] addr;
      logic [31:0] data;
   } wrExp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_req, rd_req;
   logic [15:0] wr_addr, rd_addr;
   logic [31:0] wr_data;
   logic        wr_ack, rd_ack, ram_wren, busy;
   logic [31:0] rd_data, ram_data, ram_q;
   logic [15:0] ram_address;

   logic        reset3;
   logic        wr_req3, rd_req3;
   logic [15:0] wr_addr3, rd_addr3;
   logic [31:0] wr_data3;
   logic        wr_ack3, rd_ack3, ram_wren3, busy3;
   logic [31:0] rd_data3, ram_data3, ram_q3;
   logic [15:0] ram_address3;

   int assertCount = 0;
   int failCount   = 0;

   ackExp_t     ackQ[$];
   wrExp_t      wrQ[$];
   logic [31:0] rdQ3[$];

   bit [31:0] memA [bit [15:0]];
   bit [31:0] mem3 [bit [15:0]];
   logic [31:0] qPipe3 [3];
   logic        prevWren = 1'b0;

   always #5 clk = ~clk;

   ram_port_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(1)) dut (
      .clk(clk), .reset(reset),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
      .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
      .ram_q(ram_q), .busy(busy)
   );

   ram_port_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(3)) dut3 (
      .clk(clk), .reset(reset3),
      .wr_req(wr_req3), .wr_addr(wr_addr3), .wr_data(wr_data3), .wr_ack(wr_ack3),
      .rd_req(rd_req3), .rd_addr(rd_addr3), .rd_ack(rd_ack3), .rd_data(rd_data3),
      .ram_address(ram_address3), .ram_data(ram_data3), .ram_wren(ram_wren3),
      .ram_q(ram_q3), .busy(busy3)
   );

   function automatic logic [31:0] memRead(input logic [15:0] a);
      return memA.exists(a) ? memA[a] : 32'h0;
   endfunction

   // RAM models: read-before-write, q valid RD_LAT edges after the address edge.
   always @(posedge clk) begin
      ram_q <= memRead(ram_address);
      if (ram_wren === 1'b1) memA[ram_address] = ram_data;
   end

   always @(posedge clk) begin
      qPipe3[0] <= mem3.exists(ram_address3) ? mem3[ram_address3] : 32'h0;
      qPipe3[1] <= qPipe3[0];
      qPipe3[2] <= qPipe3[1];
   end
   assign ram_q3 = qPipe3[2];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: actual %h required %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Monitor: pops expectations whenever the DUTs present a RAM write or an ack.
   always @(negedge clk) begin
      if (ram_wren === 1'b1) begin
         wrExp_t w;
         checkOutput("wren_single_cycle", 32'(prevWren), 32'd0);
         checkOutput("wr_expected_pending", 32'(wrQ.size() != 0), 32'd1);
         if (wrQ.size() != 0) begin
            w = wrQ.pop_front();
            checkOutput("ram_address", 32'(ram_address), 32'(w.addr));
            checkOutput("ram_data", ram_data, w.data);
         end
      end
      prevWren = (ram_wren === 1'b1);
      if (wr_ack === 1'b1 || rd_ack === 1'b1) begin
         ackExp_t e;
         checkOutput("ack_exclusive", 32'(wr_ack & rd_ack), 32'd0);
         checkOutput("ack_expected_pending", 32'(ackQ.size() != 0), 32'd1);
         if (ackQ.size() != 0) begin
            e = ackQ.pop_front();
            checkOutput("ack_kind_is_write", 32'(wr_ack), 32'(e.isWrite));
            if (!e.isWrite) checkOutput("rd_data", rd_data, e.data);
         end
      end
      if (rd_ack3 === 1'b1) begin
         checkOutput("rd3_ack_expected", 32'(rdQ3.size() != 0), 32'd1);
         if (rdQ3.size() != 0) checkOutput("rd3_data", rd_data3, rdQ3.pop_front());
      end
   end

   // One complete transaction on the RD_LAT=1 instance; measures grant-to-ack latency.
   task automatic applyStimulus(input bit isWrite, input logic [15:0] addr, input logic [31:0] data,
                                input bit dropEarly, input bit changeAddr, input logic [15:0] altAddr);
      int cnt;
      bit seen;
      ackQ.push_back('{isWrite, data});
      if (isWrite) wrQ.push_back('{addr, data});
      @(negedge clk);
      if (isWrite) begin
         wr_req = 1'b1; wr_addr = addr; wr_data = data;
      end else begin
         rd_req = 1'b1; rd_addr = addr;
      end
      cnt = 0;
      seen = 1'b0;
      while (!seen && cnt < 20) begin
         @(negedge clk);
         cnt++;
         if (cnt == 1) begin
            if (dropEarly) begin
               wr_req = 1'b0; rd_req = 1'b0;
            end
            if (changeAddr) begin
               wr_addr = altAddr; rd_addr = altAddr;
            end
         end
         if ((isWrite && wr_ack === 1'b1) || (!isWrite && rd_ack === 1'b1)) seen = 1'b1;
      end
      checkOutput(isWrite ? "wr_ack_latency" : "rd_ack_latency", 32'(cnt), isWrite ? 32'd2 : 32'd3);
      wr_req = 1'b0;
      rd_req = 1'b0;
   endtask

   initial begin
      int cyc;
      int acks;
      reset = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
      wr_addr = '0; rd_addr = '0; wr_data = '0;
      reset3 = 1'b0; wr_req3 = 1'b0; rd_req3 = 1'b0;
      wr_addr3 = '0; rd_addr3 = '0; wr_data3 = '0;
      mem3[16'h1234] = 32'hCAFEF00D;
      repeat (3) @(negedge clk);

      checkOutput("reset_ram_address", 32'(ram_address), 32'd0);
      checkOutput("reset_ram_data", ram_data, 32'd0);
      checkOutput("reset_ram_wren", 32'(ram_wren), 32'd0);
      checkOutput("reset_acks", 32'({wr_ack, rd_ack}), 32'd0);
      checkOutput("reset_rd_data", rd_data, 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      reset = 1'b1;

      applyStimulus(1'b1, 16'h0010, 32'hDEADBEEF, 1'b0, 1'b0, 16'h0);
      checkOutput("mem_0010", memRead(16'h0010), 32'hDEADBEEF);
      applyStimulus(1'b0, 16'h0010, 32'hDEADBEEF, 1'b0, 1'b0, 16'h0);
      @(negedge clk);
      checkOutput("rd_data_hold_1", rd_data, 32'hDEADBEEF);
      checkOutput("rd_ack_fell", 32'(rd_ack), 32'd0);
      @(negedge clk);
      checkOutput("rd_data_hold_2", rd_data, 32'hDEADBEEF);

      // Both requesters held; last grant was a read so the write wins the first tie.
`ifdef ARB_WR_PRIORITY_EN
      repeat (4) begin
         ackQ.push_back('{1'b1, 32'h0});
         wrQ.push_back('{16'h0040, 32'h11112222});
      end
`else
      repeat (2) begin
         ackQ.push_back('{1'b1, 32'h0});
         wrQ.push_back('{16'h0040, 32'h11112222});
         ackQ.push_back('{1'b0, 32'hDEADBEEF});
      end
`endif
      @(negedge clk);
      wr_req = 1'b1; wr_addr = 16'h0040; wr_data = 32'h11112222;
      rd_req = 1'b1; rd_addr = 16'h0010;
      cyc = 0;
      acks = 0;
      while (acks < 4 && cyc < 80) begin
         @(negedge clk);
         cyc++;
         if (wr_ack === 1'b1 || rd_ack === 1'b1) acks++;
      end
      checkOutput("both_req_ack_count", 32'(acks), 32'd4);
      wr_req = 1'b0;
      rd_req = 1'b0;
      repeat (2) @(negedge clk);

      applyStimulus(1'b1, 16'h0020, 32'h12345678, 1'b0, 1'b1, 16'h0030);
      @(negedge clk);
      checkOutput("addr_stable_0020", memRead(16'h0020), 32'h12345678);
      checkOutput("addr_stable_0030_untouched", memRead(16'h0030), 32'h0);
      applyStimulus(1'b0, 16'h0020, 32'h12345678, 1'b0, 1'b0, 16'h0);

      applyStimulus(1'b1, 16'hFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 16'h0);
      applyStimulus(1'b0, 16'hFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 16'h0);

      // RD_LAT=3 instance: one full read, then a read aborted by reset in its second READ cycle.
      reset3 = 1'b1;
      rdQ3.push_back(32'hCAFEF00D);
      @(negedge clk);
      rd_req3 = 1'b1; rd_addr3 = 16'h1234;
      cyc = 0;
      while (rd_ack3 !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput("rd3_ack_latency", 32'(cyc), 32'd5);
      rd_req3 = 1'b0;
      repeat (2) @(negedge clk);
      rd_req3 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checkOutput("rd3_busy_in_read", 32'(busy3), 32'd1);
      reset3 = 1'b0;
      rd_req3 = 1'b0;
      @(negedge clk);
      checkOutput("rd3_reset_busy", 32'(busy3), 32'd0);
      checkOutput("rd3_reset_rd_data", rd_data3, 32'd0);
      checkOutput("rd3_reset_ram_address", 32'(ram_address3), 32'd0);
      reset3 = 1'b1;
      repeat (10) @(negedge clk);

      checkOutput("ackQ_drained", 32'(ackQ.size()), 32'd0);
      checkOutput("wrQ_drained", 32'(wrQ.size()), 32'd0);
      checkOutput("rdQ3_drained", 32'(rdQ3.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Single-owner controller for the 16-bit-address, 32-bit-data single-port RAM.
- Shares the RAM between two requesters: the write requester (button-driven memory writer) and the read requester (sequential address scanner).
- Each requester uses a req/ack handshake. The arbiter registers the granted address, data and write-enable, waits out the RAM read latency, and returns read data.
- Replaces the free-running address mux in front of the RAM. Ownership is always explicit and writes never collide with reads.

Parameters:
- ADDR_W, 16, RAM address width.
- DATA_W, 32, RAM data width.
- RD_LAT, 1, RAM clock edges from the address-register edge to valid ram_q. Legal range 1..3.

Ports:
- clk  in  1  system clock; every register updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- wr_req  in  1  write request; held high until wr_ack is seen.
- wr_addr  in  ADDR_W  write address; sampled at grant.
- wr_data  in  DATA_W  write data; sampled at grant.
- wr_ack  out  1  one-cycle pulse; the write has completed.
- rd_req  in  1  read request; held high until rd_ack is seen.
- rd_addr  in  ADDR_W  read address; sampled at grant.
- rd_ack  out  1  one-cycle pulse; rd_data is valid.
- rd_data  out  DATA_W  captured read data; held until the next read capture.
- ram_address  out  ADDR_W  registered RAM address.
- ram_data  out  DATA_W  registered RAM write data.
- ram_wren  out  1  registered RAM write enable.
- ram_q  in  DATA_W  RAM read data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (reset==0 at an edge):
  - state=IDLE.
  - ram_address=0, ram_data=0, ram_wren=0.
  - wr_ack=0, rd_ack=0, rd_data=0.
  - last_grant=READ, so write wins the first tie.
  - Reset mid-transaction aborts it: no ack is issued and ram_wren drops at that edge.
- States: IDLE, WRITE, READ, ACK.
- IDLE:
  - Arbitrates on sampled wr_req/rd_req.
  - Only one requester high: it wins.
  - Both high: the requester not equal to last_grant wins (round-robin).
  - Neither high: stay in IDLE. ram_address and ram_data hold their previous values; ram_wren=0.
- Write grant, edge E0:
  - ram_address=wr_addr, ram_data=wr_data, ram_wren=1, last_grant=WRITE, go to WRITE.
- WRITE, edge E1: the RAM performs the write. Set ram_wren=0, wr_ack=1, go to ACK.
- Read grant, edge E0:
  - ram_address=rd_addr, ram_wren=0, wait counter=0, last_grant=READ, go to READ.
- READ:
  - Stays RD_LAT+1 cycles.
  - On the final edge (E0+RD_LAT+1): rd_data=ram_q, rd_ack=1, go to ACK.
  - RD_LAT=1: rd_ack is high in the cycle after edge E2.
- ACK:
  - Exactly one cycle; the ack pulse is high.
  - No arbitration in ACK, which gives the requester one edge to drop req.
  - Next state IDLE, where acks return to 0.
- Transaction latency, grant edge to ack-high cycle inclusive:
  - Write: 2 cycles. Write throughput: one write per 3 cycles.
  - Read: RD_LAT+2 cycles.
- Address and data are latched at grant. Later changes on wr_addr, wr_data or rd_addr are ignored until the next grant.
- Protocol violation: a requester drops req mid-transaction. The transaction still completes and the ack still pulses.
- Address values pass through unmodified. No wrap or arithmetic is applied; 0xFFFF is a legal address.
- wr_ack and rd_ack are never high in the same cycle. ram_wren is high only for the single WRITE cycle.

Optional Feature:
- Macro: ARB_WR_PRIORITY_EN.
- Defined: fixed priority. Write always wins when both requests are pending. last_grant is still maintained but ignored.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Reset then a single write:
  - Stimulus: wr_req=1, wr_addr=16'h0010, wr_data=32'hDEADBEEF.
  - Response: ram_wren=1 with address 0x0010 and data 0xDEADBEEF for exactly one cycle; wr_ack pulses 2 cycles after grant.
- Read-back, RD_LAT=1, RAM model with q valid 1 edge after the address edge:
  - Stimulus: rd_req=1, rd_addr=16'h0010.
  - Response: rd_ack pulses on the 3rd cycle after grant; rd_data=32'hDEADBEEF and holds after the ack falls.
- Simultaneous requests held continuously, both acking normally:
  - Without the macro: grant order W,R,W,R.
  - With ARB_WR_PRIORITY_EN: grant order W,W,W while wr_req stays high, and rd_ack never pulses.
- Address stability:
  - Stimulus: change wr_addr from 0x0020 to 0x0030 one cycle after grant.
  - Response: the RAM write lands at 0x0020; 0x0030 is untouched.
- Reset mid-read, RD_LAT=3:
  - Stimulus: assert reset==0 at the second READ cycle.
  - Response: state=IDLE, busy=0, rd_ack never pulses, rd_data=0, ram_address=0.
- Boundary address and early req drop:
  - Stimulus: write 32'hFFFFFFFF to 0xFFFF with wr_req dropped one cycle after grant.
  - Response: the write still occurs, wr_ack still pulses, and read-back of 0xFFFF returns 32'hFFFFFFFF.
